uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
Parametrised UART receiver for the serial console path. It supports configurable data width, parity, stop bits and oversampling, and uses majority-vote bit sampling. It reports each received frame as a one-cycle valid pulse with parity, framing and break status. It sits between the board RX pin and the core's memory-mapped UART register block.

Parameters:
CLK_FREQUENCY_HZ, 100_000_000, system clock frequency.
BAUD, 9600, line rate in bits per second.
OVERSAMPLE, 16, sample ticks per bit; even, allowed range 8..16.
DATA_BITS, 8, payload bits per frame; allowed range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line, idles high
data  output  DATA_BITS  last received payload, LSB = first bit on the wire
valid  output  1  one-cycle pulse when data and the status flags update
parity_err  output  1  parity mismatch on the last frame (0 when PARITY=0)
frame_err  output  1  a stop bit sampled low on the last frame
break_det  output  1  last frame was all zeros including parity and stop
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Clocking and reset: clk, rst synchronous active-high.
- Reset values: data=0, valid=0, all flags=0, busy=0, state=IDLE, sync flops=1, all counters=0.
- Input path: uart_rx passes through a 2-flop synchroniser. Only the synchronised value is used.
- Tick generator:
  - DIV = CLK_FREQUENCY_HZ/(BAUD*OVERSAMPLE), integer floor, minimum 1.
  - tick pulses one clk every DIV cycles.
  - Runs freely; reset clears it.
- Counters: sample_cnt counts 0..OVERSAMPLE-1 on ticks. bit_cnt counts payload and stop bits.
- Bit decision: majority of three samples taken at sample_cnt = M-1, M, M+1, where M = OVERSAMPLE/2. The decision is made at sample M+1.
- States:
  - IDLE: on a tick with synchronised rx=0, go to START, clear sample_cnt, set busy=1.
  - START: at the decision point, a majority 1 is a false start: go to IDLE, busy=0, no valid. A majority 0 means continue. At sample_cnt=OVERSAMPLE-1, go to DATA with bit_cnt=0.
  - DATA: shift the decided bit into the shift register, LSB first. After DATA_BITS bits, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: compute and store the error. Odd parity requires the XOR of payload and parity bit to be 1. Even parity requires it to be 0.
  - STOP: sample each of the STOP_BITS stop bits. Any low stop bit sets frame_err for this frame. At the decision point of the final stop bit (not at end of bit), in the next clk:
    - data <= shift register;
    - flags update;
    - valid=1 for exactly one clk.
    Then go to IDLE if the final stop bit was 1, else to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised rx has been 1 for one full bit time (OVERSAMPLE ticks), then go to IDLE. busy stays 1 throughout.
- Break detection: break_det=1 only when every payload bit, the parity bit (if present) and the first stop bit all decide 0. frame_err is then also 1.
- Holding: data and flags hold until the next valid. They are never cleared except by rst.
- Back-to-back frames: a start edge on the first tick after returning to IDLE must be accepted. No dead time is required beyond the remaining half of the stop bit.
- Reset mid-frame: state returns to IDLE, no valid is emitted, and the partial shift register is discarded.
- Latency: valid asserts 1 clk after the final stop-bit decision tick, plus 2 clks of synchroniser delay relative to the line.

Decomposition:
- Package uart_pkg holds:
  - typedef enum parity_e {PAR_NONE, PAR_ODD, PAR_EVEN};
  - typedef enum rx_state_e {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH};
  - function calc_div(clk_hz, baud, os), which returns max(1, floor);
  - function majority3.
- Sub-module uart_baud_tick (parameters CLK_FREQUENCY_HZ, BAUD, OVERSAMPLE; ports clk, rst, tick). The future transmitter will reuse it.

Test Plan:
All scenarios use CLK_FREQUENCY_HZ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16, so DIV=1 and one bit = 16 clks.
- 8N1, send 0xA5 -> one valid pulse, data=0xA5, parity_err=0, frame_err=0, break_det=0; busy falls within 8 clks of the stop-bit midpoint.
- 8E1, send 0x3C with parity bit 1 (wrong) -> valid, data=0x3C, parity_err=1. Resend with parity 0 -> parity_err=0.
- 7O2, second stop bit driven low, payload 0x55 -> data=0x55, frame_err=1, state enters WAIT_HIGH. A new frame sent before 16 high clks is ignored; the frame after is received.
- Line held low for 40 bit times (8N1) -> exactly one valid, data=0x00, frame_err=1, break_det=1. No further valid until the line has been high 16 clks and a new start occurs.
- Glitches:
  - 3-clk low pulse on an idle line -> false start, no valid, busy returns to 0.
  - Single-sample inversion at sample M of every data bit of 0xC3 -> majority vote still yields data=0xC3.
- Two back-to-back 8N1 frames 0x01 then 0xFF with no idle gap -> two valid pulses 160 clks apart, with the correct data each.
- Assert rst during bit 4 of a frame -> no valid, all outputs at reset values. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit path.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Clock cycles per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, shared by the UART receiver and transmitter.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int CLK_FREQUENCY_HZ = 100_000_000,
  parameter int BAUD             = 9600,
  parameter int OVERSAMPLE       = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_FREQUENCY_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with majority-vote bit decisions and
// parity / framing / break status reported alongside each received frame.
`timescale 1ns/1ps
module uart_rx_ext #(
  parameter int CLK_FREQUENCY_HZ = 100_000_000,
  parameter int BAUD             = 9600,
  parameter int OVERSAMPLE       = 16,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);
  import uart_pkg::*;

  // The PARITY parameter hides the package state of the same name.
  localparam rx_state_e ST_PARITY = uart_pkg::PARITY;

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_PRE    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DECIDE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    P_LAST   = 4'(STOP_BITS - 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        sample_cnt_q, sample_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic                 par_acc_q, par_acc_d;
  logic                 zero_q, zero_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic                 busy_q, busy_d;
  logic                 bit_s, decide_s, last_s, zero_stop_s;

  uart_baud_tick #(
    .CLK_FREQUENCY_HZ(CLK_FREQUENCY_HZ),
    .BAUD            (BAUD),
    .OVERSAMPLE      (OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign rx_s     = sync_q[1];
  assign bit_s    = majority3(samp_a_q, samp_b_q, rx_s);
  assign decide_s = (sample_cnt_q == S_DECIDE);
  assign last_s   = (sample_cnt_q == S_LAST);

  // Frame sequencing; every action happens on an oversample tick.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    samp_a_d     = samp_a_q;
    samp_b_d     = samp_b_q;
    par_acc_d    = par_acc_q;
    zero_d       = zero_q;
    ferr_acc_d   = ferr_acc_q;
    perr_acc_d   = perr_acc_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    brk_d        = brk_q;
    busy_d       = busy_q;
    // Break needs the first stop bit low as well as everything before it.
    zero_stop_s  = (bit_cnt_q == 4'd0) ? (zero_q & ~bit_s) : zero_q;
    if (tick) begin
      sample_cnt_d = last_s ? '0 : sample_cnt_q + SW'(1);
      samp_a_d     = (sample_cnt_q == S_PRE) ? rx_s : samp_a_q;
      samp_b_d     = (sample_cnt_q == S_MID) ? rx_s : samp_b_q;
      case (state_q)
        IDLE: begin
          sample_cnt_d = '0;
          if (!rx_s) begin
            state_d    = START;
            busy_d     = 1'b1;
            par_acc_d  = 1'b0;
            zero_d     = 1'b1;
            ferr_acc_d = 1'b0;
            perr_acc_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (decide_s && bit_s) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            sample_cnt_d = '0;
          end else if (last_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (decide_s) begin
            shift_d   = {bit_s, shift_q[DATA_BITS-1:1]};
            par_acc_d = par_acc_q ^ bit_s;
            zero_d    = zero_q & ~bit_s;
          end else if (last_s) begin
            bit_cnt_d = (bit_cnt_q == B_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
            state_d   = (bit_cnt_q != B_LAST) ? DATA : ((PARITY != 0) ? ST_PARITY : STOP);
          end else begin
            state_d = DATA;
          end
        end
        ST_PARITY: begin
          if (decide_s) begin
            perr_acc_d = (PARITY == int'(PAR_ODD)) ? ~(par_acc_q ^ bit_s) : (par_acc_q ^ bit_s);
            zero_d     = zero_q & ~bit_s;
          end else if (last_s) begin
            state_d = STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
        STOP: begin
          if (decide_s) begin
            ferr_acc_d = ferr_acc_q | ~bit_s;
            zero_d     = zero_stop_s;
            if (bit_cnt_q == P_LAST) begin
              data_d       = shift_q;
              valid_d      = 1'b1;
              perr_d       = perr_acc_q;
              ferr_d       = ferr_acc_q | ~bit_s;
              brk_d        = zero_stop_s;
              state_d      = bit_s ? IDLE : WAIT_HIGH;
              busy_d       = ~bit_s;
              sample_cnt_d = '0;
            end else begin
              state_d = STOP;
            end
          end else if (last_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d = STOP;
          end
        end
        WAIT_HIGH: begin
          // Any low sample restarts the full bit time of required idle.
          if (!rx_s) begin
            sample_cnt_d = '0;
          end else if (last_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
        default: begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          sample_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Input synchroniser, state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      samp_a_q     <= 1'b0;
      samp_b_q     <= 1'b0;
      par_acc_q    <= 1'b0;
      zero_q       <= 1'b0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], uart_rx};
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
      par_acc_q    <= par_acc_d;
      zero_q       <= zero_d;
      ferr_acc_q   <= ferr_acc_d;
      perr_acc_q   <= perr_acc_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      brk_q        <= brk_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Randomised frame-level bench for uart_rx_ext in 8N1, 8E1 and 7O2 configurations.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int OS     = 16;
  localparam int BITC   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, bd0, bd1, bd2, b0, b1, b2;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK_FREQUENCY_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .uart_rx(rx0), .data(d0), .valid(v0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .busy(b0));

  uart_rx_ext #(.CLK_FREQUENCY_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .uart_rx(rx1), .data(d1), .valid(v1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .busy(b1));

  uart_rx_ext #(.CLK_FREQUENCY_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .uart_rx(rx2), .data(d2), .valid(v2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .busy(b2));

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } rec_t;

  rec_t q0[$], q1[$], q2[$];
  time  t0[$];
  time  busy_fall_t = 0;
  int   dbl_valid = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  logic v0_p = 1'b0, v1_p = 1'b0, v2_p = 1'b0, b0_p = 1'b0;

  // Capture every reported frame away from the active edge.
  always @(negedge clk) begin
    if (v0) begin
      q0.push_back({1'b0, d0, pe0, fe0, bd0});
      t0.push_back($time);
    end
    if (v1) q1.push_back({1'b0, d1, pe1, fe1, bd1});
    if (v2) q2.push_back({2'b00, d2, pe2, fe2, bd2});
    if ((v0 && v0_p) || (v1 && v1_p) || (v2 && v2_p)) dbl_valid <= dbl_valid + 1;
    if (b0_p && !b0) busy_fall_t <= $time;
    v0_p <= v0;
    v1_p <= v1;
    v2_p <= v2;
    b0_p <= b0;
  end

  // Reference model: frame outcome from the line-level rules alone.
  function automatic logic good_parity(input logic [8:0] pay, input int nbits, input int mode);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(pay[i]);
    return (mode == 1) ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
  endfunction

  function automatic rec_t expect_rec(input logic [8:0] pay, input int nbits, input int mode,
                                      input logic pbit, input int nstop, input logic [1:0] stops);
    rec_t r;
    int   ones = 0;
    logic [8:0] d;
    d = pay & ((9'd1 << nbits) - 9'd1);
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    r.data = d;
    r.pe   = (mode == 0) ? 1'b0 :
             (mode == 1) ? logic'((ones + int'(pbit)) % 2 != 1) : logic'((ones + int'(pbit)) % 2 != 0);
    r.fe   = !stops[0] || (nstop == 2 && !stops[1]);
    r.bd   = (d == 9'd0) && (mode == 0 || !pbit) && !stops[0];
    return r;
  endfunction

  task automatic drive(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int inst, input int n);
    for (int i = 0; i < n; i++) drive(inst, 1'b1);
  endtask

  // glitch inverts one mid-bit clock of every payload bit.
  task automatic send(input int inst, input int nbits, input int mode, input logic [8:0] pay,
                      input logic pbit, input int nstop, input logic [1:0] stops, input bit glitch);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(pay[i]);
    if (mode != 0) bits.push_back(pbit);
    for (int s = 0; s < nstop; s++) bits.push_back(stops[s]);
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < BITC; c++)
        drive(inst, (glitch && k >= 1 && k <= nbits && c == 9) ? ~bits[k] : bits[k]);
  endtask

  task automatic test_reset();
    logic [13:0] o0, o1;
    logic [12:0] o2;
    o0 = {d0, v0, pe0, fe0, bd0, b0};
    o1 = {d1, v1, pe1, fe1, bd1, b1};
    o2 = {d2, v2, pe2, fe2, bd2, b2};
    n_checks++;
    if (o0 !== 14'd0) $display("FAIL reset_8n1: got %h expected 0", o0); else n_pass++;
    n_checks++;
    if (o1 !== 14'd0) $display("FAIL reset_8e1: got %h expected 0", o1); else n_pass++;
    n_checks++;
    if (o2 !== 13'd0) $display("FAIL reset_7o2: got %h expected 0", o2); else n_pass++;
  endtask

  task automatic test_8n1();
    logic [8:0] pay;
    rec_t exp, got;
    time  tstart, tmid;
    for (int k = 0; k < 5; k++) begin
      pay = (k == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
      q0.delete();
      tstart = $time;
      send(0, 8, 0, pay, 1'b0, 1, 2'b11, 1'b0);
      idle(0, 24);
      exp = expect_rec(pay, 8, 0, 1'b0, 1, 2'b11);
      got = (q0.size() > 0) ? q0[0] : '0;
      n_checks++;
      if (q0.size() != 1 || got !== exp)
        $display("FAIL 8n1_frame[%0d]: got n=%0d rec=%h expected n=1 rec=%h", k, q0.size(), got, exp);
      else n_pass++;
      if (k == 0) begin
        tmid = tstart + time'((9 * BITC + 8) * 10);
        n_checks++;
        if (busy_fall_t < tmid || busy_fall_t > tmid + 80)
          $display("FAIL 8n1_busy_fall: got t=%0t expected within 80ns after %0t", busy_fall_t, tmid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_parity();
    logic [8:0] pay;
    logic       pbit;
    rec_t exp, got;
    for (int k = 0; k < 5; k++) begin
      pay  = (k < 2) ? 9'h03C : 9'($urandom_range(0, 255));
      pbit = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : logic'($urandom_range(0, 1));
      q1.delete();
      send(1, 8, 2, pay, pbit, 1, 2'b11, 1'b0);
      idle(1, 24);
      exp = expect_rec(pay, 8, 2, pbit, 1, 2'b11);
      got = (q1.size() > 0) ? q1[0] : '0;
      n_checks++;
      if (q1.size() != 1 || got !== exp)
        $display("FAIL 8e1_frame[%0d]: got n=%0d rec=%h expected n=1 rec=%h", k, q1.size(), got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_7o2_wait_high();
    logic [8:0] pay;
    rec_t exp, got;
    q2.delete();
    send(2, 7, 1, 9'h055, good_parity(9'h055, 7, 1), 2, 2'b01, 1'b0);
    idle(2, 8);
    n_checks++;
    if (b2 !== 1'b1) $display("FAIL 7o2_wait_busy: got %b expected 1", b2); else n_pass++;
    exp = expect_rec(9'h055, 7, 1, good_parity(9'h055, 7, 1), 2, 2'b01);
    got = (q2.size() > 0) ? q2[0] : '0;
    n_checks++;
    if (q2.size() != 1 || got !== exp)
      $display("FAIL 7o2_frame_err: got n=%0d rec=%h expected n=1 rec=%h", q2.size(), got, exp);
    else n_pass++;
    q2.delete();
    send(2, 7, 1, 9'h000, good_parity(9'h000, 7, 1), 2, 2'b11, 1'b0);
    n_checks++;
    if (q2.size() != 0) $display("FAIL 7o2_ignored: got n=%0d expected n=0", q2.size()); else n_pass++;
    pay = 9'($urandom_range(0, 127));
    send(2, 7, 1, pay, good_parity(pay, 7, 1), 2, 2'b11, 1'b0);
    idle(2, 24);
    exp = expect_rec(pay, 7, 1, good_parity(pay, 7, 1), 2, 2'b11);
    got = (q2.size() > 0) ? q2[0] : '0;
    n_checks++;
    if (q2.size() != 1 || got !== exp)
      $display("FAIL 7o2_after: got n=%0d rec=%h expected n=1 rec=%h", q2.size(), got, exp);
    else n_pass++;
  endtask

  task automatic test_break();
    logic [8:0] pay;
    rec_t exp, got;
    q0.delete();
    for (int i = 0; i < 40 * BITC; i++) drive(0, 1'b0);
    exp = expect_rec(9'h000, 8, 0, 1'b0, 1, 2'b00);
    got = (q0.size() > 0) ? q0[0] : '0;
    n_checks++;
    if (q0.size() != 1 || got !== exp)
      $display("FAIL break_frame: got n=%0d rec=%h expected n=1 rec=%h", q0.size(), got, exp);
    else n_pass++;
    n_checks++;
    if (b0 !== 1'b1) $display("FAIL break_busy: got %b expected 1", b0); else n_pass++;
    idle(0, 40);
    n_checks++;
    if (q0.size() != 1) $display("FAIL break_no_more: got n=%0d expected n=1", q0.size()); else n_pass++;
    pay = 9'($urandom_range(1, 255));
    send(0, 8, 0, pay, 1'b0, 1, 2'b11, 1'b0);
    idle(0, 24);
    exp = expect_rec(pay, 8, 0, 1'b0, 1, 2'b11);
    got = (q0.size() > 1) ? q0[1] : '0;
    n_checks++;
    if (q0.size() != 2 || got !== exp)
      $display("FAIL break_next: got n=%0d rec=%h expected n=2 rec=%h", q0.size(), got, exp);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [8:0] pay;
    rec_t exp, got;
    q0.delete();
    for (int i = 0; i < 3; i++) drive(0, 1'b0);
    idle(0, 3);
    n_checks++;
    if (b0 !== 1'b1) $display("FAIL glitch_busy_rise: got %b expected 1", b0); else n_pass++;
    idle(0, 40);
    n_checks++;
    if (q0.size() != 0 || b0 !== 1'b0)
      $display("FAIL glitch_false_start: got n=%0d busy=%b expected n=0 busy=0", q0.size(), b0);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      pay = (k == 0) ? 9'h0C3 : 9'($urandom_range(0, 255));
      q0.delete();
      send(0, 8, 0, pay, 1'b0, 1, 2'b11, 1'b1);
      idle(0, 24);
      exp = expect_rec(pay, 8, 0, 1'b0, 1, 2'b11);
      got = (q0.size() > 0) ? q0[0] : '0;
      n_checks++;
      if (q0.size() != 1 || got !== exp)
        $display("FAIL glitch_majority[%0d]: got n=%0d rec=%h expected n=1 rec=%h", k, q0.size(), got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    rec_t e1, e2, g1, g2;
    time  dt;
    q0.delete();
    t0.delete();
    send(0, 8, 0, 9'h001, 1'b0, 1, 2'b11, 1'b0);
    send(0, 8, 0, 9'h0FF, 1'b0, 1, 2'b11, 1'b0);
    idle(0, 24);
    e1 = expect_rec(9'h001, 8, 0, 1'b0, 1, 2'b11);
    e2 = expect_rec(9'h0FF, 8, 0, 1'b0, 1, 2'b11);
    g1 = (q0.size() > 0) ? q0[0] : '0;
    g2 = (q0.size() > 1) ? q0[1] : '0;
    n_checks++;
    if (q0.size() != 2 || g1 !== e1)
      $display("FAIL b2b_first: got n=%0d rec=%h expected n=2 rec=%h", q0.size(), g1, e1);
    else n_pass++;
    n_checks++;
    if (g2 !== e2) $display("FAIL b2b_second: got rec=%h expected rec=%h", g2, e2); else n_pass++;
    dt = (t0.size() > 1) ? t0[1] - t0[0] : 0;
    n_checks++;
    if (dt != time'(10 * BITC * 10)) $display("FAIL b2b_spacing: got %0t expected 1600", dt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [8:0]  pay;
    logic [13:0] o0;
    rec_t exp, got;
    pay = 9'h05A;
    q0.delete();
    for (int c = 0; c < BITC; c++) drive(0, 1'b0);
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < BITC; c++) drive(0, pay[b]);
    for (int c = 0; c < BITC / 2; c++) drive(0, pay[4]);
    rst = 1'b1;
    idle(0, 3);
    o0 = {d0, v0, pe0, fe0, bd0, b0};
    n_checks++;
    if (o0 !== 14'd0) $display("FAIL rst_mid_outputs: got %h expected 0", o0); else n_pass++;
    rst = 1'b0;
    idle(0, 40);
    n_checks++;
    if (q0.size() != 0 || b0 !== 1'b0)
      $display("FAIL rst_mid_no_valid: got n=%0d busy=%b expected n=0 busy=0", q0.size(), b0);
    else n_pass++;
    send(0, 8, 0, 9'h081, 1'b0, 1, 2'b11, 1'b0);
    idle(0, 24);
    exp = expect_rec(9'h081, 8, 0, 1'b0, 1, 2'b11);
    got = (q0.size() > 0) ? q0[0] : '0;
    n_checks++;
    if (q0.size() != 1 || got !== exp)
      $display("FAIL rst_mid_next: got n=%0d rec=%h expected n=1 rec=%h", q0.size(), got, exp);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    idle(0, 20);
    test_8n1();
    test_parity();
    test_7o2_wait_high();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (dbl_valid != 0) $display("FAIL valid_one_cycle: got %0d long pulses expected 0", dbl_valid);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
